// File: rtl/axi_rd_arbiter_n.sv
// -----------------------------------------------------------------------------
// axi_rd_arbiter_n
// Merges NUM_MASTERS AXI3 read masters (AR + R) onto one downstream AXI read
// port. Each master may have one burst outstanding. The master index travels
// in m_arid, and the R channel is routed back by m_rid through a one-entry
// buffer per master. The buffered beat carries the master's original ARID.
//
// Ports
//   clk, reset                    clock; asynchronous active-high reset
//   s_ar* / s_arready             per-master AR channel, master i at [i*W +: W]
//   s_r*  / s_rready              per-master R channel (buffered)
//   m_ar* / m_arready             merged AR channel (registered payload)
//   m_r*  / m_rready              downstream R channel
//   err_stray                     one-cycle pulse after a beat with m_rid >= NUM_MASTERS
//
// AR FSM states
//   state | meaning
//   IDLE  | arbitrate; the winner sees s_arready this cycle and its payload is latched
//   ISSUE | m_arvalid held with a stable payload until m_arready
// -----------------------------------------------------------------------------
module axi_rd_arbiter_n #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 4,
    parameter int ARB_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS*ID_W-1:0]   s_arid,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
    input  logic [NUM_MASTERS*4-1:0]      s_arlen,
    input  logic [NUM_MASTERS*3-1:0]      s_arsize,
    input  logic [NUM_MASTERS*2-1:0]      s_arburst,
    input  logic [NUM_MASTERS-1:0]        s_arvalid,
    output logic [NUM_MASTERS-1:0]        s_arready,
    output logic [NUM_MASTERS*ID_W-1:0]   s_rid,
    output logic [NUM_MASTERS*DATA_W-1:0] s_rdata,
    output logic [NUM_MASTERS*2-1:0]      s_rresp,
    output logic [NUM_MASTERS-1:0]        s_rlast,
    output logic [NUM_MASTERS-1:0]        s_rvalid,
    input  logic [NUM_MASTERS-1:0]        s_rready,
    output logic [ID_W-1:0]               m_arid,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [3:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [1:0]                    m_arlock,
    output logic [3:0]                    m_arcache,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [ID_W-1:0]               m_rid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready,
    output logic                          err_stray
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, ISSUE} ar_state_t;

    ar_state_t               state, state_nxt;
    logic [NUM_MASTERS-1:0]  busy, eligible, grant_oh;
    logic [NUM_MASTERS-1:0]  rbuf_full, rbuf_last, r_match, r_acc, r_drain;
    logic [IDX_W-1:0]        ptr, grant_idx;
    logic                    grant_vld, r_stray;
    logic [ID_W-1:0]         id_tab    [NUM_MASTERS];
    logic [DATA_W-1:0]       rbuf_data [NUM_MASTERS];
    logic [1:0]              rbuf_resp [NUM_MASTERS];

    assign m_arlock  = '0;
    assign m_arcache = '0;
    assign m_arprot  = '0;

    // position k steps after p, modulo NUM_MASTERS (k <= NUM_MASTERS)
    function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return IDX_W'(s);
    endfunction

    // Arbitration. Later loop iterations overwrite earlier ones, so iteration
    // order is chosen so that the last hit is the winner.
    always_comb begin
        eligible  = s_arvalid & ~busy;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (eligible[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                if (eligible[rr_pos(ptr, k)]) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_pos(ptr, k);
                end
            end
        end
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        s_arready = '0;
        m_arvalid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    s_arready = grant_oh;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // R routing: an unknown m_rid matches no buffer and is always accepted.
    // A full buffer still accepts when its master drains it this cycle.
    always_comb begin
        r_match = '0;
        for (int i = 0; i < NUM_MASTERS; i++) r_match[i] = (m_rid == ID_W'(i));
        r_stray  = ~|r_match;
        m_rready = r_stray | ~|(r_match & rbuf_full & ~s_rready);
        r_acc    = r_match & {NUM_MASTERS{m_rvalid & m_rready}};
        r_drain  = rbuf_full & s_rready;
    end

    always_comb begin
        s_rvalid = rbuf_full;
        s_rlast  = rbuf_full & rbuf_last;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            s_rid[i*ID_W +: ID_W]     = id_tab[i];
            s_rdata[i*DATA_W +: DATA_W] = rbuf_data[i];
            s_rresp[i*2 +: 2]         = rbuf_resp[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= IDX_W'(NUM_MASTERS - 1);
            busy      <= '0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
            err_stray <= 1'b0;
            rbuf_full <= '0;
            rbuf_last <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                id_tab[i]    <= '0;
                rbuf_data[i] <= '0;
                rbuf_resp[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            err_stray <= m_rvalid & r_stray;
            if (state == IDLE && grant_vld) begin
                m_arid            <= ID_W'(grant_idx);
                m_araddr          <= s_araddr[grant_idx*ADDR_W +: ADDR_W];
                m_arlen           <= s_arlen[grant_idx*4 +: 4];
                m_arsize          <= s_arsize[grant_idx*3 +: 3];
                m_arburst         <= s_arburst[grant_idx*2 +: 2];
                id_tab[grant_idx] <= s_arid[grant_idx*ID_W +: ID_W];
                if (ARB_MODE == 0) ptr <= grant_idx;
            end
            for (int i = 0; i < NUM_MASTERS; i++) begin
                // a master cannot be granted while busy, so set and clear never collide
                if (r_drain[i] & rbuf_last[i])
                    busy[i] <= 1'b0;
                else if (state == IDLE && grant_oh[i])
                    busy[i] <= 1'b1;

                if (r_acc[i]) begin
                    rbuf_full[i] <= 1'b1;
                    rbuf_data[i] <= m_rdata;
                    rbuf_resp[i] <= m_rresp;
                    rbuf_last[i] <= m_rlast;
                end else if (r_drain[i]) begin
                    rbuf_full[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// Bench for axi_rd_arbiter_n: a round-robin 3-master instance driven by a
// cycle-level reference model plus a slave model, and a small fixed-priority
// 2-master instance exercised directly.
module tb_axi_rd_arbiter_n;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // main DUT: NUM_MASTERS=3, round-robin
    logic [11:0] s_arid;
    logic [95:0] s_araddr;
    logic [11:0] s_arlen;
    logic [8:0]  s_arsize;
    logic [5:0]  s_arburst;
    logic [2:0]  s_arvalid, s_arready;
    logic [11:0] s_rid;
    logic [95:0] s_rdata;
    logic [5:0]  s_rresp;
    logic [2:0]  s_rlast, s_rvalid, s_rready;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [3:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [1:0]  m_arlock;
    logic [3:0]  m_arcache;
    logic [2:0]  m_arprot;
    logic        m_arvalid, m_arready;
    logic [3:0]  m_rid;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast, m_rvalid, m_rready, err_stray;

    axi_rd_arbiter_n #(.NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .ID_W(4), .ARB_MODE(0)) u_dut (
        .clk(clk), .reset(reset),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err_stray(err_stray)
    );

    // second DUT: NUM_MASTERS=2, fixed priority
    logic [7:0]  fp_s_arid;
    logic [63:0] fp_s_araddr;
    logic [7:0]  fp_s_arlen;
    logic [5:0]  fp_s_arsize;
    logic [3:0]  fp_s_arburst;
    logic [1:0]  fp_s_arvalid, fp_s_arready;
    logic [7:0]  fp_s_rid;
    logic [63:0] fp_s_rdata;
    logic [3:0]  fp_s_rresp;
    logic [1:0]  fp_s_rlast, fp_s_rvalid, fp_s_rready;
    logic [3:0]  fp_m_arid;
    logic [31:0] fp_m_araddr;
    logic [3:0]  fp_m_arlen;
    logic [2:0]  fp_m_arsize;
    logic [1:0]  fp_m_arburst;
    logic [1:0]  fp_m_arlock;
    logic [3:0]  fp_m_arcache;
    logic [2:0]  fp_m_arprot;
    logic        fp_m_arvalid, fp_m_arready;
    logic [3:0]  fp_m_rid;
    logic [31:0] fp_m_rdata;
    logic [1:0]  fp_m_rresp;
    logic        fp_m_rlast, fp_m_rvalid, fp_m_rready, fp_err_stray;

    axi_rd_arbiter_n #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .ID_W(4), .ARB_MODE(1)) u_fp (
        .clk(clk), .reset(reset),
        .s_arid(fp_s_arid), .s_araddr(fp_s_araddr), .s_arlen(fp_s_arlen), .s_arsize(fp_s_arsize),
        .s_arburst(fp_s_arburst), .s_arvalid(fp_s_arvalid), .s_arready(fp_s_arready),
        .s_rid(fp_s_rid), .s_rdata(fp_s_rdata), .s_rresp(fp_s_rresp), .s_rlast(fp_s_rlast),
        .s_rvalid(fp_s_rvalid), .s_rready(fp_s_rready),
        .m_arid(fp_m_arid), .m_araddr(fp_m_araddr), .m_arlen(fp_m_arlen), .m_arsize(fp_m_arsize),
        .m_arburst(fp_m_arburst), .m_arlock(fp_m_arlock), .m_arcache(fp_m_arcache), .m_arprot(fp_m_arprot),
        .m_arvalid(fp_m_arvalid), .m_arready(fp_m_arready),
        .m_rid(fp_m_rid), .m_rdata(fp_m_rdata), .m_rresp(fp_m_rresp), .m_rlast(fp_m_rlast),
        .m_rvalid(fp_m_rvalid), .m_rready(fp_m_rready), .err_stray(fp_err_stray)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    typedef struct {int m; int beats;} burst_t;
    burst_t      sq[$];
    int          md_state, md_last, md_g, cyc, err_seen;
    logic [2:0]  md_busy, buf_full, buf_last;
    logic [31:0] md_addr;
    logic [3:0]  md_len;
    logic [2:0]  md_size;
    logic [1:0]  md_burst;
    logic [3:0]  orig_id [3];
    logic [31:0] buf_data [3];
    logic [1:0]  buf_resp [3];
    logic        err_exp;
    int          exp_beats [3];
    int          got_beats [3];
    int          grant_log[$];
    int          av_cyc[$];
    logic [4:0]  d0_log[$];
    logic [4:0]  d0_ent;
    // slave model
    logic        sl_valid, sl_last, inject_stray, rand_en, done_f;
    logic [3:0]  sl_rid;
    logic [31:0] sl_data;
    logic [1:0]  sl_resp;
    int          e0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] elig);
        for (int k = 1; k <= 3; k++) begin
            if (elig[(md_last + k) % 3]) return (md_last + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        s_arvalid[i]          = 1'b1;
        s_arid[i*4 +: 4]      = id;
        s_araddr[i*32 +: 32]  = addr;
        s_arlen[i*4 +: 4]     = len;
        s_arsize[i*3 +: 3]    = 3'd2;
        s_arburst[i*2 +: 2]   = 2'd1;
    endtask

    task automatic drive_random();
        for (int i = 0; i < 3; i++) begin
            if (!s_arvalid[i] && $urandom_range(0, 3) == 0) begin
                set_req(i, 4'($urandom), $urandom, 4'($urandom));
                s_arsize[i*3 +: 3]  = 3'($urandom_range(0, 2));
                s_arburst[i*2 +: 2] = 2'($urandom_range(0, 2));
            end
        end
        s_rready  = 3'($urandom);
        m_arready = ($urandom_range(0, 2) != 0);
    endtask

    // Called at posedge+1 with inputs set; checks, advances the model, and
    // returns at the next posedge+1.
    task automatic cycle_check();
        logic [2:0] elig, gmask;
        int g;
        bit stray, exp_rr, acc;
        gmask = '0;
        g = -1;
        if (reset) begin
            sl_valid = 1'b0;
            sq.delete();
        end else if (!sl_valid) begin
            if (inject_stray || (rand_en && $urandom_range(0, 39) == 0)) begin
                inject_stray = 1'b0;
                sl_valid = 1'b1; sl_rid = 4'd7; sl_data = $urandom;
                sl_resp = 2'($urandom); sl_last = 1'b1;
            end else if (sq.size() > 0 && (!rand_en || $urandom_range(0, 3) != 0)) begin
                sl_valid = 1'b1; sl_rid = 4'(sq[0].m); sl_data = $urandom;
                sl_resp = 2'($urandom); sl_last = (sq[0].beats == 1);
            end
        end
        m_rvalid = sl_valid;
        m_rid    = sl_rid;
        m_rdata  = sl_data;
        m_rresp  = sl_resp;
        m_rlast  = sl_valid & sl_last;
        #1;
        if (reset) begin
            chk("rst_m_arvalid", m_arvalid, 0);
            chk("rst_s_rvalid", s_rvalid, 0);
            chk("rst_err_stray", err_stray, 0);
            chk("rst_m_arid", m_arid, 0);
            chk("rst_tied", {m_arlock, m_arcache, m_arprot}, 0);
            md_state = 0; md_busy = '0; md_last = 2; buf_full = '0; buf_last = '0; err_exp = 1'b0;
        end else begin
            elig = s_arvalid & ~md_busy;
            if (md_state == 0) begin
                if (elig != 0) begin
                    g = pick(elig);
                    gmask[g] = 1'b1;
                end
                chk("s_arready", s_arready, gmask);
                chk("m_arvalid_idle", m_arvalid, 0);
            end else begin
                chk("s_arready_issue", s_arready, 0);
                chk("m_arvalid_issue", m_arvalid, 1);
                chk("m_arid", m_arid, md_g);
                chk("m_araddr", m_araddr, md_addr);
                chk("m_arlen", m_arlen, md_len);
                chk("m_arsize", m_arsize, md_size);
                chk("m_arburst", m_arburst, md_burst);
            end
            for (int i = 0; i < 3; i++) begin
                chk("s_rvalid", s_rvalid[i], buf_full[i]);
                if (buf_full[i]) begin
                    chk("s_rid", s_rid[i*4 +: 4], orig_id[i]);
                    chk("s_rdata", s_rdata[i*32 +: 32], buf_data[i]);
                    chk("s_rresp", s_rresp[i*2 +: 2], buf_resp[i]);
                    chk("s_rlast", s_rlast[i], buf_last[i]);
                end
            end
            chk("err_stray", err_stray, err_exp);
            if (err_stray === 1'b1) err_seen++;
            stray  = (sl_rid >= 3);
            exp_rr = stray ? 1'b1 : !(buf_full[sl_rid] && !s_rready[sl_rid]);
            if (sl_valid) chk("m_rready", m_rready, exp_rr);
            acc = sl_valid && exp_rr;
            // model update for the coming edge
            for (int i = 0; i < 3; i++) begin
                if (buf_full[i] && s_rready[i]) begin
                    got_beats[i]++;
                    if (i == 0) d0_log.push_back({s_rid[3:0], s_rlast[0]});
                    if (buf_last[i]) md_busy[i] = 1'b0;
                    buf_full[i] = 1'b0;
                end
            end
            if (acc && !stray) begin
                buf_full[sl_rid] = 1'b1;
                buf_data[sl_rid] = sl_data;
                buf_resp[sl_rid] = sl_resp;
                buf_last[sl_rid] = sl_last;
                sq[0].beats = sq[0].beats - 1;
                if (sq[0].beats == 0) void'(sq.pop_front());
            end
            err_exp = acc && stray;
            if (acc) sl_valid = 1'b0;
            if (m_arvalid === 1'b1) av_cyc.push_back(cyc);
            if (md_state == 0 && g >= 0) begin
                md_busy[g] = 1'b1; md_last = g; md_g = g;
                md_addr  = s_araddr[g*32 +: 32];
                md_len   = s_arlen[g*4 +: 4];
                md_size  = s_arsize[g*3 +: 3];
                md_burst = s_arburst[g*2 +: 2];
                orig_id[g] = s_arid[g*4 +: 4];
                md_state = 1;
                grant_log.push_back(g);
            end else if (md_state == 1 && m_arready) begin
                md_state = 0;
                sq.push_back('{md_g, int'(md_len) + 1});
                exp_beats[md_g] += int'(md_len) + 1;
            end
        end
        @(posedge clk);
        #1;
        s_arvalid = s_arvalid & ~gmask;
        cyc++;
    endtask

    initial begin
        reset = 1'b1;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
        m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        fp_s_arid = 8'h21; fp_s_araddr = {32'hB000_0000, 32'hA000_0000};
        fp_s_arlen = '0; fp_s_arsize = '0; fp_s_arburst = '0; fp_s_arvalid = '0;
        fp_s_rready = 2'b11; fp_m_arready = 1'b0;
        fp_m_rid = '0; fp_m_rdata = '0; fp_m_rresp = '0; fp_m_rlast = 1'b0; fp_m_rvalid = 1'b0;
        sl_valid = 1'b0; sl_last = 1'b0; sl_rid = '0; sl_data = '0; sl_resp = '0;
        inject_stray = 1'b0; rand_en = 1'b0; done_f = 1'b0;
        md_state = 0; md_busy = '0; md_last = 2; md_g = 0; buf_full = '0; buf_last = '0;
        md_addr = '0; md_len = '0; md_size = '0; md_burst = '0; err_exp = 1'b0;
        cyc = 0; err_seen = 0; e0 = 0;
        for (int i = 0; i < 3; i++) begin
            exp_beats[i] = 0; got_beats[i] = 0; orig_id[i] = '0; buf_data[i] = '0; buf_resp[i] = '0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        cycle_check();
        reset = 1'b0;

        // fixed priority: both request, highest index first, then master 0
        fp_s_arvalid = 2'b11;
        #1 chk("fp_first_grant", fp_s_arready, 2'b10);
        cycle_check();
        fp_s_arvalid = 2'b01;
        #1;
        chk("fp_arvalid1", fp_m_arvalid, 1);
        chk("fp_arid1", fp_m_arid, 1);
        chk("fp_araddr1", fp_m_araddr, 32'hB000_0000);
        chk("fp_arready_issue", fp_s_arready, 0);
        fp_m_arready = 1'b1;
        cycle_check();
        #1;
        chk("fp_arvalid_drop", fp_m_arvalid, 0);
        chk("fp_second_grant", fp_s_arready, 2'b01);
        cycle_check();
        fp_s_arvalid = 2'b00;
        #1;
        chk("fp_arvalid0", fp_m_arvalid, 1);
        chk("fp_arid0", fp_m_arid, 0);
        cycle_check();

        // round-robin: all three request in cycle 0
        s_rready = 3'b111; m_arready = 1'b1;
        grant_log.delete(); av_cyc.delete(); cyc = 0;
        for (int i = 0; i < 3; i++) set_req(i, 4'hA + 4'(i), 32'h1000 * (i + 1), 4'd0);
        repeat (12) cycle_check();
        chk("rr_grant_count", grant_log.size(), 3);
        if (grant_log.size() >= 3) begin
            chk("rr_grant0", grant_log[0], 0);
            chk("rr_grant1", grant_log[1], 1);
            chk("rr_grant2", grant_log[2], 2);
        end
        chk("rr_av_count", av_cyc.size(), 3);
        if (av_cyc.size() >= 3) begin
            chk("rr_av_cyc0", av_cyc[0], 1);
            chk("rr_av_cyc1", av_cyc[1], 3);
            chk("rr_av_cyc2", av_cyc[2], 5);
        end

        // master 0, ARID=A, four-beat burst
        d0_log.delete();
        set_req(0, 4'hA, 32'h0000_4000, 4'd3);
        repeat (14) cycle_check();
        chk("burst_beats", d0_log.size(), 4);
        for (int k = 0; k < d0_log.size(); k++) begin
            d0_ent = d0_log[k];
            chk("burst_rid", d0_ent[4:1], 4'hA);
            chk("burst_rlast", d0_ent[0], (k == 3));
        end

        // stray response id
        e0 = err_seen;
        inject_stray = 1'b1;
        repeat (4) cycle_check();
        chk("stray_pulses", err_seen - e0, 1);

        // randomized traffic
        rand_en = 1'b1;
        repeat (1500) begin
            drive_random();
            cycle_check();
        end

        // drain everything outstanding
        rand_en = 1'b0; s_rready = 3'b111; m_arready = 1'b1;
        for (int t = 0; t < 400 && !done_f; t++) begin
            cycle_check();
            done_f = (sq.size() == 0 && s_arvalid == 3'b000 && md_state == 0 &&
                      buf_full == 3'b000 && !sl_valid);
        end
        chk("drain_done", done_f, 1);
        for (int i = 0; i < 3; i++) chk("beats_delivered", got_beats[i], exp_beats[i]);

        // reset during ISSUE with a beat parked in master 2's buffer
        s_rready = 3'b000;
        set_req(2, 4'h3, 32'h2000, 4'd0);
        repeat (4) cycle_check();
        m_arready = 1'b0;
        set_req(1, 4'h5, 32'h3000, 4'd1);
        repeat (2) cycle_check();
        reset = 1'b1;
        s_arvalid = 3'b000;
        cycle_check();
        reset = 1'b0;
        s_rready = 3'b111; m_arready = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 3; i++) set_req(i, 4'(i), 32'h5000 + i, 4'd0);
        repeat (8) cycle_check();
        chk("post_reset_grants", grant_log.size(), 3);
        if (grant_log.size() >= 1) chk("post_reset_first", grant_log[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
